// File: rtl/mem_system.sv
// Accumulator datapath: 8-entry register bank, ALU with post-shifter, CNPZ flags,
// and MAR/MDR/IR registers wrapped around an internal single-port RAM.
module mem_system #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ir_sclr,
    input  logic                  mar_sclr,
    input  logic                  enaf,
    input  logic [2:0]            selop,
    input  logic [1:0]            shamt,
    input  logic                  bank_wr_en,
    input  logic [2:0]            busB_addr,
    input  logic [2:0]            busC_addr,
    input  logic                  ir_en,
    input  logic                  mar_en,
    input  logic                  wr_rdn,
    input  logic                  mdr_alu_n,
    input  logic                  mdr_en,
    output logic [DATA_WIDTH-1:0] busC_m,
    output logic [DATA_WIDTH-1:0] bus_alu_m,
    output logic [DATA_WIDTH-1:0] PC_m,
    output logic [DATA_WIDTH-1:0] DPTR_m,
    output logic [DATA_WIDTH-1:0] A_m,
    output logic [DATA_WIDTH-1:0] TEMP_m,
    output logic [DATA_WIDTH-1:0] ACC_m,
    output logic [4:0]            instruction,
    output logic                  C,
    output logic                  N,
    output logic                  P,
    output logic                  Z
);
    localparam int W = DATA_WIDTH;

    logic [W-1:0] bank [8];
    logic [W-1:0] ram [2**W];
    logic [W-1:0] mar;
    logic [W-1:0] mdr;
    logic [4:0]   ir;
    logic         c_q, n_q, p_q, z_q;

    logic [W-1:0] bus_b;
    logic [W-1:0] x;
    logic [W:0]   sum;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic [W-1:0] bus_alu;
    logic [W-1:0] bus_c;

    assign bus_b = bank[busB_addr];
    assign x     = bank[7];

    // Arithmetic ops use a W+1 wide sum; the top bit is carry (or borrow for sub).
    always_comb begin
        sum     = '0;
        alu_res = bus_b;
        alu_c   = 1'b0;
        unique case (selop)
            3'b000: alu_res = bus_b;
            3'b001: begin
                sum     = {1'b0, x} + {1'b0, bus_b};
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
            end
            3'b010: alu_res = x & bus_b;
            3'b011: alu_res = x | bus_b;
            3'b100: alu_res = x ^ bus_b;
            3'b101: alu_res = ~bus_b;
            3'b110: begin
                sum     = {1'b0, bus_b} + {{W{1'b0}}, 1'b1};
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
            end
            3'b111: begin
                sum     = {1'b0, x} - {1'b0, bus_b};
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
            end
        endcase
    end

    always_comb begin
        bus_alu = alu_res;
        unique case (shamt)
            2'b00: bus_alu = alu_res;
            2'b01: bus_alu = {alu_res[W-2:0], 1'b0};
            2'b10: bus_alu = {1'b0, alu_res[W-1:1]};
            2'b11: bus_alu = {alu_res[0], alu_res[W-1:1]};
        endcase
    end

    assign bus_c = mdr_alu_n ? mdr : bus_alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else if (bank_wr_en) begin
            bank[busC_addr] <= bus_c;
        end
    end

    // Flags track the ALU/shifter path even when bus C is sourced from MDR.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
            n_q <= 1'b0;
            p_q <= 1'b0;
            z_q <= 1'b0;
        end else if (enaf) begin
            c_q <= alu_c;
            n_q <= bus_alu[W-1];
            p_q <= ^bus_alu;
            z_q <= ~|bus_alu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mar <= '0;
        end else if (mar_sclr) begin
            mar <= '0;
        end else if (mar_en) begin
            mar <= bus_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mdr <= '0;
        end else if (mdr_en) begin
            mdr <= wr_rdn ? bus_b : ram[mar];
        end
    end

    // RAM has no reset; a reset cycle merely suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && !mdr_en && wr_rdn) begin
            ram[mar] <= mdr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= '0;
        end else if (ir_sclr) begin
            ir <= '0;
        end else if (ir_en) begin
            ir <= mdr[W-1 -: 5];
        end
    end

    assign busC_m      = bus_c;
    assign bus_alu_m   = bus_alu;
    assign PC_m        = bank[0];
    assign DPTR_m      = bank[1];
    assign TEMP_m      = bank[2];
    assign A_m         = bank[3];
    assign ACC_m       = bank[7];
    assign instruction = ir;
    assign C           = c_q;
    assign N           = n_q;
    assign P           = p_q;
    assign Z           = z_q;

endmodule

// File: tb/tb_mem_system.sv
// Bench for mem_system: directed walk through the datapath then random
// control words, all checked against a behavioural model of the datapath.
module tb_mem_system;
    logic       clk = 1'b0;
    logic       rst, ir_sclr, mar_sclr, enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busB_addr, busC_addr;
    logic       ir_en, mar_en, wr_rdn, mdr_alu_n, mdr_en;
    logic [7:0] busC_m, bus_alu_m, PC_m, DPTR_m, A_m, TEMP_m, ACC_m;
    logic [4:0] instruction;
    logic       C, N, P, Z;

    int checks = 0;
    int failures = 0;

    int m_bank [8];
    int m_mar, m_mdr, m_ir;
    bit m_c, m_n, m_p, m_z;
    int m_ram [256];
    bit m_ok [256];

    int seen_alu, seen_busc;

    mem_system #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .ir_sclr(ir_sclr), .mar_sclr(mar_sclr),
        .enaf(enaf), .selop(selop), .shamt(shamt),
        .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
        .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en),
        .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n), .mdr_en(mdr_en),
        .busC_m(busC_m), .bus_alu_m(bus_alu_m), .PC_m(PC_m),
        .DPTR_m(DPTR_m), .A_m(A_m), .TEMP_m(TEMP_m), .ACC_m(ACC_m),
        .instruction(instruction), .C(C), .N(N), .P(P), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 0; ir_sclr = 0; mar_sclr = 0; enaf = 0;
        selop = 0; shamt = 0; bank_wr_en = 0;
        busB_addr = 0; busC_addr = 0; ir_en = 0; mar_en = 0;
        wr_rdn = 0; mdr_alu_n = 0; mdr_en = 0;
    endtask

    function automatic void alu_ref(input int x, input int y, input int op,
                                    output int r, output bit c);
        c = 0;
        case (op)
            0: r = y;
            1: begin r = x + y; c = (r > 255); r = r % 256; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 255 - y;
            6: begin r = y + 1; c = (r > 255); r = r % 256; end
            default: begin c = (x < y); r = (x - y + 256) % 256; end
        endcase
    endfunction

    function automatic int shf_ref(input int r, input int sh);
        case (sh)
            0: return r;
            1: return (r * 2) % 256;
            2: return r / 2;
            default: return (r / 2) + ((r % 2) * 128);
        endcase
    endfunction

    task automatic cycle();
        int x, y, r, s, bc, nm_mdr;
        bit c;
        logic [7:0] sv;
        @(negedge clk);
        y = m_bank[busB_addr];
        x = m_bank[7];
        alu_ref(x, y, int'(selop), r, c);
        s  = shf_ref(r, int'(shamt));
        bc = mdr_alu_n ? m_mdr : s;
        seen_alu  = int'(bus_alu_m);
        seen_busc = int'(busC_m);
        chk("bus_alu", bus_alu_m, s);
        chk("busC", busC_m, bc);
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (m_bank[i]) m_bank[i] = 0;
            m_mar = 0; m_mdr = 0; m_ir = 0;
            m_c = 0; m_n = 0; m_p = 0; m_z = 0;
        end else begin
            nm_mdr = m_mdr;
            if (mdr_en && !wr_rdn) nm_mdr = m_ram[m_mar];
            if (mdr_en && wr_rdn) nm_mdr = y;
            if (!mdr_en && wr_rdn) begin
                m_ram[m_mar] = m_mdr;
                m_ok[m_mar]  = 1;
            end
            if (ir_sclr) m_ir = 0;
            else if (ir_en) m_ir = m_mdr / 8;
            if (mar_sclr) m_mar = 0;
            else if (mar_en) m_mar = y;
            m_mdr = nm_mdr;
            if (bank_wr_en) m_bank[busC_addr] = bc;
            if (enaf) begin
                sv  = 8'(s);
                m_c = c;
                m_n = (s >= 128);
                m_z = (s == 0);
                m_p = $countones(sv) % 2;
            end
        end
        chk("PC", PC_m, m_bank[0]);
        chk("DPTR", DPTR_m, m_bank[1]);
        chk("TEMP", TEMP_m, m_bank[2]);
        chk("A", A_m, m_bank[3]);
        chk("ACC", ACC_m, m_bank[7]);
        chk("IR", instruction, m_ir);
        chk("C", C, m_c);
        chk("N", N, m_n);
        chk("P", P, m_p);
        chk("Z", Z, m_z);
    endtask

    initial begin
        foreach (m_bank[i]) m_bank[i] = 0;
        foreach (m_ok[i]) m_ok[i] = 0;
        m_mar = 0; m_mdr = 0; m_ir = 0;
        m_c = 0; m_n = 0; m_p = 0; m_z = 0;
        idle();
        rst = 1;
        cycle();
        chk("rst_acc", ACC_m, 0);
        chk("rst_ir", instruction, 0);

        idle();
        selop = 3'b010; busB_addr = 3; busC_addr = 7;
        bank_wr_en = 1; enaf = 1;
        cycle();
        chk("and0_acc", ACC_m, 8'h00);
        chk("and0_flags", {C, N, P, Z}, 4'b0001);

        idle();
        selop = 3'b110; busB_addr = 3; busC_addr = 3; bank_wr_en = 1;
        repeat (3) cycle();
        chk("inc3_a", A_m, 8'h03);

        selop = 3'b000; busC_addr = 7;
        cycle();
        chk("mov_acc", ACC_m, 8'h03);

        selop = 3'b010; busC_addr = 3; enaf = 1;
        cycle();
        chk("and_a", A_m, 8'h03);
        chk("and_pz", {P, Z}, 2'b00);

        selop = 3'b111; busC_addr = 2;
        cycle();
        chk("sub_res", TEMP_m, 8'h00);
        chk("sub_cz", {C, Z}, 2'b01);

        idle();
        selop = 3'b001; shamt = 2'b01; busB_addr = 3;
        cycle();
        chk("add_shl", seen_alu, 8'h0C);

        idle();
        selop = 3'b101; busB_addr = 2; busC_addr = 3; bank_wr_en = 1;
        cycle();
        chk("not_a", A_m, 8'hFF);
        selop = 3'b110; busB_addr = 3; enaf = 1;
        cycle();
        chk("inc_wrap", A_m, 8'h00);
        chk("inc_c", C, 1'b1);

        idle();
        selop = 3'b110; bank_wr_en = 1;
        busB_addr = 1; busC_addr = 1;
        repeat (5) cycle();
        busB_addr = 4; busC_addr = 4;
        repeat (163) cycle();

        idle(); mar_en = 1; busB_addr = 1; cycle();
        idle(); mdr_en = 1; wr_rdn = 1; busB_addr = 4; cycle();
        idle(); wr_rdn = 1; cycle();
        idle(); mdr_en = 1; wr_rdn = 1; busB_addr = 2; cycle();
        idle(); mdr_alu_n = 1; mdr_en = 1; cycle();
        chk("mdr_cleared", seen_busc, 8'h00);
        idle(); mdr_alu_n = 1; bank_wr_en = 1; busC_addr = 2; cycle();
        chk("mem_rt", TEMP_m, 8'hA3);

        idle(); ir_en = 1; cycle();
        chk("ir_load", instruction, 5'b10100);
        idle(); ir_en = 1; ir_sclr = 1; cycle();
        chk("ir_sclr", instruction, 5'b00000);

        idle(); mar_sclr = 1; mar_en = 1; busB_addr = 1; cycle();
        idle(); mdr_en = 1; wr_rdn = 1; busB_addr = 1; cycle();
        idle(); wr_rdn = 1; cycle();
        idle(); mar_en = 1; busB_addr = 1; cycle();
        idle(); mdr_en = 1; cycle();
        idle(); mdr_alu_n = 1; cycle();
        chk("mar_sclr", seen_busc, 8'hA3);

        idle();
        rst = 1; bank_wr_en = 1; enaf = 1; busC_addr = 7;
        selop = 3'b101; busB_addr = 2;
        cycle();
        chk("mid_rst", {PC_m, DPTR_m, A_m, TEMP_m}, 32'h0);
        chk("mid_rst_f", {ACC_m, instruction, C, N, P, Z}, 17'h0);

        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 63) == 0);
            ir_sclr    = ($urandom_range(0, 7) == 0);
            mar_sclr   = ($urandom_range(0, 7) == 0);
            enaf       = 1'($urandom);
            selop      = 3'($urandom);
            shamt      = 2'($urandom);
            bank_wr_en = 1'($urandom);
            busB_addr  = 3'($urandom);
            busC_addr  = 3'($urandom);
            ir_en      = 1'($urandom);
            mar_en     = 1'($urandom);
            wr_rdn     = 1'($urandom);
            mdr_alu_n  = 1'($urandom);
            mdr_en     = 1'($urandom);
            if (mdr_en && !wr_rdn && !m_ok[m_mar]) mdr_en = 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
